// File: rtl/sensor_packet_collector.sv
// sensor_packet_collector: reassembles in-order sensor ID 0..7 packets into 64-bit frames, aborting on bad IDs, error flags or timeouts (optional error counter under SENSOR_COLLECTOR_ERRCNT_EN)
module sensor_packet_collector #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] packet_in,
   input  logic        pkt_valid,
   input  logic        pkt_error,
   output logic [63:0] frame_out,
   output logic        frame_valid,
   output logic        seq_error,
   output logic [7:0]  error_count
);
   typedef enum logic {SYNC, COLLECT} state_t;
   state_t state, state_n;
   logic [2:0] id, exp_id, exp_id_n;
   logic [7:0] data, idle_cnt, idle_cnt_n;
   logic [6:0][7:0] shadow;
   logic start, good, bad, tmo, done, store;
   // classify the current packet and compute the next state
   always_comb begin
      id = packet_in[10:8];
      data = packet_in[7:0];
      start = pkt_valid && !pkt_error && id == 3'd0;
      good = state == COLLECT && pkt_valid && !pkt_error && id == exp_id;
      bad = state == COLLECT && pkt_valid && !good;
      tmo = state == COLLECT && !pkt_valid && idle_cnt == 8'(TIMEOUT - 1);
      done = good && id == 3'd7;
      store = (state == SYNC && start) || good || (bad && start);
      state_n = state == SYNC ? (start ? COLLECT : SYNC) :
                done          ? SYNC :
                bad           ? (start ? COLLECT : SYNC) :
                tmo           ? SYNC : COLLECT;
      exp_id_n = store ? id + 3'd1 : exp_id;
      idle_cnt_n = (state == COLLECT && !pkt_valid && !tmo) ? idle_cnt + 8'd1 : 8'd0;
   end
   // state, expected ID and idle counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SYNC;
         exp_id <= 3'd0;
         idle_cnt <= 8'd0;
      end else begin
         state <= state_n;
         exp_id <= exp_id_n;
         idle_cnt <= idle_cnt_n;
      end
   end
   // shadow slots, completed frame and event strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         frame_out <= '0;
         frame_valid <= 1'b0;
         seq_error <= 1'b0;
      end else begin
         for (int k = 0; k < 7; k++)
            if (store && id == 3'(k)) shadow[k] <= data;
         if (done) frame_out <= {data, shadow};
         frame_valid <= done;
         seq_error <= bad || tmo;
      end
   end
`ifdef SENSOR_COLLECTOR_ERRCNT_EN
   // saturating count of aborted frames
   always_ff @(posedge clk) begin
      if (rst) error_count <= 8'd0;
      else if ((bad || tmo) && error_count != 8'hff) error_count <= error_count + 8'd1;
   end
`else
   assign error_count = 8'h00;
`endif
endmodule

// File: tb/tb_sensor_packet_collector.sv
// tb_sensor_packet_collector: directed vector table plus reset and saturation sequences
module tb_sensor_packet_collector;
   typedef struct {
      logic        v;
      logic        e;
      logic [2:0]  id;
      logic [7:0]  d;
      logic        fv;
      logic        se;
      int          n;
      logic [63:0] fo;
   } vec_t;

   localparam logic [63:0] F1 = 64'h6699_5533_0FF0_CCAA;
   localparam logic [63:0] F2 = 64'h0807_0605_0403_0201;
   localparam logic [63:0] F3 = 64'h1716_1514_1312_1110;
   localparam logic [63:0] F4 = 64'h2726_2524_2322_2120;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] packet_in = '0;
   logic        pkt_valid = 1'b0;
   logic        pkt_error = 1'b0;
   logic [63:0] frame_out;
   logic        frame_valid;
   logic        seq_error;
   logic [7:0]  error_count;

   int   total = 0;
   int   passed = 0;
   vec_t vecs[$];

   sensor_packet_collector #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .packet_in(packet_in), .pkt_valid(pkt_valid),
      .pkt_error(pkt_error), .frame_out(frame_out), .frame_valid(frame_valid),
      .seq_error(seq_error), .error_count(error_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_cnt(input int n);
`ifdef SENSOR_COLLECTOR_ERRCNT_EN
      return n > 255 ? 8'hff : 8'(n);
`else
      return 8'h00;
`endif
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic add(input logic v, input logic e, input logic [2:0] id, input logic [7:0] d,
                      input logic fv, input logic se, input int n, input logic [63:0] fo);
      vec_t t;
      t.v = v; t.e = e; t.id = id; t.d = d; t.fv = fv; t.se = se; t.n = n; t.fo = fo;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic v, input logic e, input logic [2:0] id, input logic [7:0] d);
      @(negedge clk);
      pkt_valid = v;
      pkt_error = e;
      packet_in = {id, d};
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] cln [8];
      cln = '{8'hAA, 8'hCC, 8'hF0, 8'h0F, 8'h33, 8'h55, 8'h99, 8'h66};
      add(1, 0, 3'd3, 8'h11, 0, 0, 0, 64'h0);
      for (int k = 0; k < 8; k++) add(1, 0, 3'(k), cln[k], k == 7, 0, 0, k == 7 ? F1 : 64'h0);
      add(0, 0, 3'd0, 8'h00, 0, 0, 0, F1);
      add(1, 0, 3'd0, 8'h01, 0, 0, 0, F1);
      add(1, 0, 3'd1, 8'h02, 0, 0, 0, F1);
      add(1, 0, 3'd3, 8'h04, 0, 1, 1, F1);
      for (int k = 0; k < 8; k++) add(1, 0, 3'(k), 8'(k + 1), k == 7, 0, 1, k == 7 ? F2 : F1);
      add(1, 0, 3'd0, 8'h30, 0, 0, 1, F2);
      add(1, 0, 3'd1, 8'h31, 0, 0, 1, F2);
      add(1, 1, 3'd2, 8'h32, 0, 1, 2, F2);
      add(1, 0, 3'd0, 8'h40, 0, 0, 2, F2);
      add(1, 0, 3'd1, 8'h41, 0, 0, 2, F2);
      add(1, 0, 3'd0, 8'h10, 0, 1, 3, F2);
      for (int k = 1; k < 8; k++) add(1, 0, 3'(k), 8'(8'h10 + k), k == 7, 0, 3, k == 7 ? F3 : F2);
      add(1, 1, 3'd0, 8'h55, 0, 0, 3, F3);
      add(1, 0, 3'd0, 8'h50, 0, 0, 3, F3);
      add(1, 0, 3'd1, 8'h51, 0, 0, 3, F3);
      for (int k = 0; k < 3; k++) add(0, 0, 3'd0, 8'h00, 0, 0, 3, F3);
      add(0, 0, 3'd0, 8'h00, 0, 1, 4, F3);
      add(0, 0, 3'd0, 8'h00, 0, 0, 4, F3);
      add(1, 0, 3'd0, 8'h20, 0, 0, 4, F3);
      add(1, 0, 3'd1, 8'h21, 0, 0, 4, F3);
      for (int k = 0; k < 3; k++) add(0, 0, 3'd0, 8'h00, 0, 0, 4, F3);
      for (int k = 2; k < 8; k++) add(1, 0, 3'(k), 8'(8'h20 + k), k == 7, 0, 4, k == 7 ? F4 : F3);

      repeat (2) @(posedge clk);
      #1;
      chk("reset frame_out", frame_out, 64'h0);
      chk("reset frame_valid", 64'(frame_valid), 64'h0);
      chk("reset seq_error", 64'(seq_error), 64'h0);
      chk("reset error_count", 64'(error_count), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].e, vecs[i].id, vecs[i].d);
         chk($sformatf("vec%0d frame_valid", i), 64'(frame_valid), 64'(vecs[i].fv));
         chk($sformatf("vec%0d seq_error", i), 64'(seq_error), 64'(vecs[i].se));
         chk($sformatf("vec%0d error_count", i), 64'(error_count), 64'(exp_cnt(vecs[i].n)));
         chk($sformatf("vec%0d frame_out", i), frame_out, vecs[i].fo);
      end

      drive(1, 0, 3'd0, 8'h70);
      drive(1, 0, 3'd1, 8'h71);
      @(negedge clk);
      rst = 1'b1;
      packet_in = {3'd2, 8'h72};
      @(posedge clk);
      #1;
      chk("midreset frame_out", frame_out, 64'h0);
      chk("midreset error_count", 64'(error_count), 64'h0);
      chk("midreset seq_error", 64'(seq_error), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k < 8; k++) begin
         drive(1, 0, 3'(k), 8'(8'h70 + k));
         chk($sformatf("postreset id%0d frame_valid", k), 64'(frame_valid), 64'h0);
         chk($sformatf("postreset id%0d seq_error", k), 64'(seq_error), 64'h0);
      end
      chk("postreset frame_out", frame_out, 64'h0);

      for (int k = 0; k < 260; k++) begin
         drive(1, 0, 3'd0, 8'h01);
         drive(1, 0, 3'd2, 8'h02);
         if (k == 253) chk("sat count 254", 64'(error_count), 64'(exp_cnt(254)));
      end
      chk("sat seq_error", 64'(seq_error), 64'h1);
      chk("sat error_count", 64'(error_count), 64'(exp_cnt(260)));
      chk("sat frame_out", frame_out, 64'h0);

      drive(0, 0, 3'd0, 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sensor_packet_collector.md
# sensor_packet_collector

Downstream consumer of `sensor_system`'s 11-bit packet stream. It samples `{id[2:0], data[7:0]}` packets and checks that sensor IDs arrive in order 0..7. A complete, error-free frame is reassembled into a 64-bit word and announced with a one-cycle strobe. Out-of-order IDs, flagged packets and stalled frames abort the partial frame and are reported.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum idle cycles, with `pkt_valid` low, allowed inside a partial frame before it is aborted (range 1..255).

Ports (clock and reset first):
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `packet_in`  input  11  `[10:8]` sensor ID, `[7:0]` sensor data.
- `pkt_valid`  input  1  `packet_in` and `pkt_error` are meaningful this cycle.
- `pkt_error`  input  1  upstream error flag accompanying the packet.
- `frame_out`  output  64  last complete frame; sensor k at `[8k+7:8k]`.
- `frame_valid`  output  1  one-cycle strobe; `frame_out` was just updated.
- `seq_error`  output  1  one-cycle strobe; the partial frame was aborted.
- `error_count`  output  8  saturating count of `seq_error` events.

## Operation

- **Reset:** state SYNC, expected ID 0, idle counter 0, shadow buffer 0. `frame_out` = 0, `frame_valid` = 0, `seq_error` = 0, `error_count` = 0. Reset asserted mid-frame discards the partial frame; `frame_out` also clears.
- **SYNC state:** waits for a packet with `pkt_valid`=1, `pkt_error`=0 and ID 0.
  - On that packet: store the data in shadow slot 0, set expected ID to 1, go to COLLECT.
  - Any other valid packet is dropped silently. There is no `seq_error` and no count change.
- **COLLECT state**, on a valid packet:
  - **Good packet** (`pkt_error`=0 and ID equals the expected ID):
    - Store the data in that shadow slot.
    - If the ID is 7: copy shadow slots 0..6 plus the current data into `frame_out`, pulse `frame_valid`, and go to SYNC.
    - Otherwise: increment the expected ID.
  - **Bad packet** (`pkt_error`=1, or ID differs from the expected ID):
    - Pulse `seq_error`, increment `error_count`, discard the partial frame.
    - If the bad packet itself has ID 0 with `pkt_error`=0, it starts a new frame: store slot 0, expected ID = 1, stay in COLLECT.
    - Otherwise go to SYNC.
- **Timeout, COLLECT with `pkt_valid`=0:**
  - The idle counter increments each such cycle and clears on every valid packet.
  - When the counter reaches `TIMEOUT`: pulse `seq_error`, increment `error_count`, go to SYNC.
  - The idle counter is inactive in SYNC.
- **Output behaviour:**
  - `frame_out` changes only on frame completion or reset. Partial or aborted frames never reach it.
  - `error_count` saturates at 255.

## Timing

- All outputs are registered.
- The id-7 packet sampled at edge N gives `frame_out` updated and `frame_valid`=1 during cycle N..N+1. `frame_valid` returns to 0 at edge N+1 unless another frame completes.
- Minimum frame spacing is 8 cycles (back-to-back valid packets). `frame_valid` therefore never asserts on consecutive cycles.
- A bad packet sampled at edge N gives `seq_error`=1 and the incremented `error_count` during cycle N..N+1.
- Timeout: the last valid packet at edge N with no valid packets afterwards gives `seq_error` after edge N+`TIMEOUT`.
- `seq_error` and `frame_valid` are mutually exclusive in any cycle.
- `rst` has priority over every other input in the same cycle.

## Configuration

- Macro `SENSOR_COLLECTOR_ERRCNT_EN`.
- **Defined:** the 8-bit saturating `error_count` register is implemented as described.
- **Undefined:** the counter is not built, `error_count` is tied to 8'h00, and `seq_error` behaviour is unchanged.

## Test plan

- **Reset clears outputs:** `rst`=1 for 2 cycles -> all outputs 0 and state SYNC. Then a valid ID-3 packet -> no `seq_error`, `error_count` stays 0.
- **Clean frame:** IDs 0..7 back-to-back with data AA, CC, F0, 0F, 33, 55, 99, 66 -> one `frame_valid` pulse one cycle after the ID-7 packet, `frame_out` = 64'h6699_5533_0FF0_CCAA, `seq_error` never asserts.
- **Out-of-order ID:** IDs 0, 1, 3 -> `seq_error` pulses once after ID 3, `error_count`=1, `frame_out` unchanged.
  - Then a clean 0..7 frame with data 01..08 -> `frame_out` = 64'h0807_0605_0403_0201.
- **Error flag and resync:**
  - ID 2 sent with `pkt_error`=1 mid-frame -> `seq_error`, count increments.
  - ID 0 arriving as the bad packet in COLLECT -> `seq_error` pulses and a new frame starts; IDs 1..7 that follow complete it with `frame_valid`.
- **Timeout and stall:** `TIMEOUT`=4; IDs 0, 1, then `pkt_valid` low for 4 cycles -> `seq_error` on the 4th idle edge. A 3-cycle stall mid-frame -> no error and the frame completes.
- **Saturation (macro defined):** 260 aborted frames -> `error_count` = 255. With the macro undefined, the same stimulus -> `error_count` = 0.
